pawn_move_ctrl: RTL and testbench

Sequential move controller that owns the 8x8 board register and drives the pawn legality checker. It accepts a source square then a destination square from the UI, presents the source square to the pawn checker, samples its three allow bits, and commits legal pawn moves to the board. It also tracks whose turn it is and detects king capture.

---
 rtl/pawn_move_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pawn_move_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pawn_move_ctrl.sv
// pawn_move_ctrl: move controller owning the 8x8 board register.
// Takes a source then a destination square, asks the external pawn checker
// (via row/column/color) which steps are allowed, and commits legal pawn moves.
// Ports:
//   clk, reset            - rising-edge clock, async active-high reset
//   sel_valid/row/col     - one-cycle square selection strobe from the UI
//   pawnAllow[2:0]        - checker result: [2] forward, [1] diag-left, [0] diag-right
//   boardPos              - board, per square {king, black, occupied}
//   row, column, color    - latched source square and side to move
//   busy                  - high while evaluating/committing; selections dropped
//   move_done, move_err   - one-cycle result pulses
//   game_over, winner     - sticky king-capture flag and capturing color
module pawn_move_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel_valid,
  input  logic [2:0]            sel_row,
  input  logic [2:0]            sel_col,
  input  logic [2:0]            pawnAllow,
  output logic [7:0][7:0][2:0]  boardPos,
  output logic [2:0]            row,
  output logic [2:0]            column,
  output logic                  color,
  output logic                  busy,
  output logic                  move_done,
  output logic                  move_err,
  output logic                  game_over,
  output logic                  winner
);

  localparam int unsigned SQ_W = 3;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_CHECK, S_COMMIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IDX_W-1:0] r_dst_row;
  logic [IDX_W-1:0] r_dst_col;

  // Starting layout: black pawns row 1, white pawns row 6, kings in column 4
  function automatic logic [7:0][7:0][SQ_W-1:0] init_board();
    logic [7:0][7:0][SQ_W-1:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[1][IDX_W'(c)] = 3'b011;
      b[6][IDX_W'(c)] = 3'b001;
    end
    b[0][4] = 3'b111;
    b[7][4] = 3'b101;
    return b;
  endfunction

  logic [SQ_W-1:0] w_sel_sq;
  logic [SQ_W-1:0] w_src_sq;
  logic            w_dst_king;
  logic            w_src_ok;
  logic            w_same_sq;
  logic [3:0]      w_fwd_row;
  logic [3:0]      w_col_m1;
  logic [3:0]      w_col_p1;
  logic            w_legal;

  assign w_sel_sq   = boardPos[sel_row][sel_col];
  assign w_src_sq   = boardPos[row][column];
  assign w_dst_king = boardPos[r_dst_row][r_dst_col][2];
  assign w_src_ok   = w_sel_sq[0] && (w_sel_sq[1] == color) && !w_sel_sq[2];
  assign w_same_sq  = (sel_row == row) && (sel_col == column);

  // 4-bit arithmetic so edge squares yield out-of-range values (15 or 8)
  // that never equal a zero-extended 3-bit destination index.
  assign w_fwd_row = color ? ({1'b0, row} + 4'd1) : ({1'b0, row} - 4'd1);
  assign w_col_m1  = {1'b0, column} - 4'd1;
  assign w_col_p1  = {1'b0, column} + 4'd1;
  assign w_legal   = ({1'b0, r_dst_row} == w_fwd_row) &&
                     (((r_dst_col == column) && pawnAllow[2]) ||
                      (({1'b0, r_dst_col} == w_col_m1) && pawnAllow[1]) ||
                      (({1'b0, r_dst_col} == w_col_p1) && pawnAllow[0]));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (sel_valid && !game_over && w_src_ok) w_state_nxt = S_SRC;
      S_SRC:    if (sel_valid) w_state_nxt = w_same_sq ? S_IDLE : S_CHECK;
      S_CHECK:  w_state_nxt = w_legal ? S_COMMIT : S_IDLE;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  logic [7:0][7:0][SQ_W-1:0] w_board_nxt;
  logic [IDX_W-1:0]          w_row_nxt;
  logic [IDX_W-1:0]          w_col_nxt;
  logic [IDX_W-1:0]          w_dst_row_nxt;
  logic [IDX_W-1:0]          w_dst_col_nxt;
  logic                      w_color_nxt;
  logic                      w_busy_nxt;
  logic                      w_done_nxt;
  logic                      w_err_nxt;
  logic                      w_over_nxt;
  logic                      w_winner_nxt;

  // Output / datapath next values
  always_comb begin
    w_board_nxt   = boardPos;
    w_row_nxt     = row;
    w_col_nxt     = column;
    w_dst_row_nxt = r_dst_row;
    w_dst_col_nxt = r_dst_col;
    w_color_nxt   = color;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_over_nxt    = game_over;
    w_winner_nxt  = winner;
    case (r_state)
      S_IDLE: begin
        if (sel_valid) begin
          if (game_over || !w_src_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            w_row_nxt = sel_row;
            w_col_nxt = sel_col;
          end
        end
      end
      S_SRC: begin
        if (sel_valid && !w_same_sq) begin
          w_dst_row_nxt = sel_row;
          w_dst_col_nxt = sel_col;
        end
      end
      S_CHECK: begin
        if (!w_legal) w_err_nxt = 1'b1;
      end
      S_COMMIT: begin
        w_board_nxt[r_dst_row][r_dst_col] = w_src_sq;
        w_board_nxt[row][column]          = 3'b000;
        w_color_nxt                       = ~color;
        w_done_nxt                        = 1'b1;
        if (w_dst_king) begin
          w_over_nxt   = 1'b1;
          w_winner_nxt = color;
        end
      end
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt == S_CHECK) || (w_state_nxt == S_COMMIT);
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boardPos  <= init_board();
      row       <= '0;
      column    <= '0;
      r_dst_row <= '0;
      r_dst_col <= '0;
      color     <= 1'b0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      boardPos  <= w_board_nxt;
      row       <= w_row_nxt;
      column    <= w_col_nxt;
      r_dst_row <= w_dst_row_nxt;
      r_dst_col <= w_dst_col_nxt;
      color     <= w_color_nxt;
      busy      <= w_busy_nxt;
      move_done <= w_done_nxt;
      move_err  <= w_err_nxt;
      game_over <= w_over_nxt;
      winner    <= w_winner_nxt;
    end
  end

endmodule

// File: tb/tb_pawn_move_ctrl.sv
// tb_pawn_move_ctrl: directed, table-driven bench for pawn_move_ctrl.
// Includes a behavioural pawn checker driving pawnAllow (with an override
// for forcing all allow bits) and a board/color scoreboard.
module tb_pawn_move_ctrl;

  logic                 clk;
  logic                 reset;
  logic                 sel_valid;
  logic [2:0]           sel_row;
  logic [2:0]           sel_col;
  logic [2:0]           pawnAllow;
  logic [7:0][7:0][2:0] boardPos;
  logic [2:0]           row;
  logic [2:0]           column;
  logic                 color;
  logic                 busy;
  logic                 move_done;
  logic                 move_err;
  logic                 game_over;
  logic                 winner;

  pawn_move_ctrl dut (
    .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel_row(sel_row),
    .sel_col(sel_col), .pawnAllow(pawnAllow), .boardPos(boardPos), .row(row),
    .column(column), .color(color), .busy(busy), .move_done(move_done),
    .move_err(move_err), .game_over(game_over), .winner(winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pawn checker
  logic       ovr;
  logic [2:0] ovr_val;

  function automatic logic [2:0] pawn_chk(input logic [2:0] r, input logic [2:0] c,
                                          input logic clr, input logic [7:0][7:0][2:0] b);
    logic [2:0] a;
    int fr;
    int cc;
    a  = 3'b000;
    cc = int'(c);
    fr = clr ? int'(r) + 1 : int'(r) - 1;
    if (fr >= 0 && fr <= 7) begin
      if (!b[3'(fr)][c][0]) a[2] = 1'b1;
      if (cc > 0 && b[3'(fr)][3'(cc-1)][0] && (b[3'(fr)][3'(cc-1)][1] != clr)) a[1] = 1'b1;
      if (cc < 7 && b[3'(fr)][3'(cc+1)][0] && (b[3'(fr)][3'(cc+1)][1] != clr)) a[0] = 1'b1;
    end
    return a;
  endfunction

  assign pawnAllow = ovr ? ovr_val : pawn_chk(row, column, color, boardPos);

  // Scoreboard
  logic [7:0][7:0][2:0] exp_board;
  logic                 exp_color;
  int                   n_tests;
  int                   n_fail;

  function automatic logic [7:0][7:0][2:0] start_board();
    logic [7:0][7:0][2:0] b;
    b = '0;
    b[1] = {8{3'b011}};
    b[6] = {8{3'b001}};
    b[0][4] = 3'b111;
    b[7][4] = 3'b101;
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_board(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Drive one selection strobe; starts and ends on a falling edge.
  task automatic strobe(input logic [2:0] r, input logic [2:0] c);
    sel_row   = r;
    sel_col   = c;
    sel_valid = 1'b1;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0] sr;
    logic [2:0] sc;
    logic [2:0] dr;
    logic [2:0] dc;
    logic       ovr;
    logic [2:0] allow;
    logic       src_ok;
    logic       legal;
  } vec_t;

  task automatic run_vec(input int i, input vec_t v);
    ovr     = v.ovr;
    ovr_val = v.allow;
    strobe(v.sr, v.sc);
    if (!v.src_ok) begin
      check($sformatf("v%0d src_reject_err", i), 32'(move_err), 32'(1));
      check($sformatf("v%0d src_reject_busy", i), 32'(busy), 32'(0));
      @(negedge clk);
      check($sformatf("v%0d err_one_cycle", i), 32'(move_err), 32'(0));
      check_board($sformatf("v%0d board_after_reject", i), 192'(boardPos), 192'(exp_board));
    end else begin
      check($sformatf("v%0d src_latch", i), 32'({move_err, busy, row, column}),
            32'({1'b0, 1'b0, v.sr, v.sc}));
      strobe(v.dr, v.dc);
      check($sformatf("v%0d check_busy", i), 32'(busy), 32'(1));
      @(negedge clk);
      if (v.legal) begin
        check($sformatf("v%0d commit_state", i), 32'({busy, move_err, move_done}), 32'(3'b100));
        @(negedge clk);
        exp_board[v.dr][v.dc] = exp_board[v.sr][v.sc];
        exp_board[v.sr][v.sc] = 3'b000;
        exp_color = ~exp_color;
        check($sformatf("v%0d done_pulse", i), 32'({busy, move_done}), 32'(2'b01));
      end else begin
        check($sformatf("v%0d reject_pulse", i), 32'({busy, move_err, move_done}), 32'(3'b010));
      end
      check_board($sformatf("v%0d board", i), 192'(boardPos), 192'(exp_board));
      check($sformatf("v%0d color", i), 32'(color), 32'(exp_color));
      @(negedge clk);
      check($sformatf("v%0d pulses_clear", i), 32'({move_done, move_err}), 32'(0));
    end
    ovr = 1'b0;
  endtask

  localparam int NV = 17;
  vec_t vecs[NV];

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    sel_valid = 1'b0;
    sel_row   = '0;
    sel_col   = '0;
    ovr       = 1'b0;
    ovr_val   = '0;
    exp_board = start_board();
    exp_color = 1'b0;

    //         sr    sc    dr    dc    ovr   allow   src_ok legal
    vecs[0]  = '{3'd6, 3'd3, 3'd5, 3'd3, 1'b0, 3'b000, 1'b1, 1'b1}; // white forward
    vecs[1]  = '{3'd1, 3'd4, 3'd2, 3'd4, 1'b0, 3'b000, 1'b1, 1'b1}; // black forward
    vecs[2]  = '{3'd1, 3'd3, 3'd0, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0}; // wrong color source
    vecs[3]  = '{3'd6, 3'd0, 3'd5, 3'd7, 1'b1, 3'b111, 1'b1, 1'b0}; // column wrap attempt
    vecs[4]  = '{3'd7, 3'd4, 3'd0, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0}; // king as source
    vecs[5]  = '{3'd6, 3'd6, 3'd4, 3'd6, 1'b0, 3'b000, 1'b1, 1'b0}; // double step
    vecs[6]  = '{3'd6, 3'd2, 3'd5, 3'd2, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[7]  = '{3'd2, 3'd4, 3'd3, 3'd4, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[8]  = '{3'd5, 3'd2, 3'd4, 3'd2, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[9]  = '{3'd3, 3'd4, 3'd4, 3'd4, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[10] = '{3'd4, 3'd2, 3'd3, 3'd2, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[11] = '{3'd4, 3'd4, 3'd5, 3'd4, 1'b0, 3'b000, 1'b1, 1'b1}; // black lands on (5,4)
    vecs[12] = '{3'd6, 3'd4, 3'd5, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0}; // blocked forward
    vecs[13] = '{3'd3, 3'd2, 3'd2, 3'd2, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[14] = '{3'd1, 3'd7, 3'd2, 3'd7, 1'b0, 3'b000, 1'b1, 1'b1};
    vecs[15] = '{3'd2, 3'd2, 3'd1, 3'd3, 1'b0, 3'b000, 1'b1, 1'b1}; // diag-right capture
    vecs[16] = '{3'd2, 3'd7, 3'd3, 3'd7, 1'b0, 3'b000, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_board("reset_board", 192'(boardPos), 192'(exp_board));
    check("reset_outputs",
          32'({row, column, color, busy, move_done, move_err, game_over, winner}), 32'(0));

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Deselect: re-selecting the source returns to idle without error
    strobe(3'd6, 3'd7);
    check("deselect_src_latch", 32'({row, column}), 32'({3'd6, 3'd7}));
    strobe(3'd6, 3'd7);
    check("deselect_no_err", 32'({busy, move_err}), 32'(0));
    @(negedge clk);
    check("deselect_quiet", 32'({busy, move_err, move_done}), 32'(0));

    // King capture by white pawn at (1,3)
    run_vec(100, '{3'd1, 3'd3, 3'd0, 3'd4, 1'b0, 3'b000, 1'b1, 1'b1});
    check("king_sq", 32'(boardPos[0][4]), 32'(3'b001));
    check("game_over_set", 32'({game_over, winner}), 32'(2'b10));
    strobe(3'd1, 3'd0);
    check("over_sel_err", 32'({move_err, busy}), 32'(2'b10));
    check("over_src_not_latched", 32'({row, column}), 32'({3'd1, 3'd3}));
    @(negedge clk);
    check("over_sticky", 32'({game_over, move_err}), 32'(2'b10));

    // Reset clears game over
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_board = start_board();
    exp_color = 1'b0;
    @(negedge clk);
    check("reset_clears_over", 32'({game_over, winner, color}), 32'(0));

    // Reset asserted mid-move while in CHECK
    strobe(3'd6, 3'd1);
    strobe(3'd5, 3'd1);
    check("pre_abort_busy", 32'({busy, row, column}), 32'({1'b1, 3'd6, 3'd1}));
    #2 reset = 1'b1;
    #1;
    check_board("abort_board_async", 192'(boardPos), 192'(exp_board));
    check("abort_outputs_async",
          32'({row, column, color, busy, move_done, move_err, game_over, winner}), 32'(0));
    @(negedge clk);
    check_board("abort_board_held", 192'(boardPos), 192'(exp_board));
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({busy, move_done, move_err}), 32'(0));

    // Recovery after the aborted move
    run_vec(200, '{3'd6, 3'd1, 3'd5, 3'd1, 1'b0, 3'b000, 1'b1, 1'b1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
